instr_mem_responder: RTL and testbench

- Responder end of the instruction-fetch bus; the fetch stage is the initiator on the req/gnt/addr/rdata/rvalid/err handshake.
- Holds a word-organised instruction memory and accepts address requests while fewer than MAX_OUTSTANDING are in flight.
- Returns read data in order, exactly LATENCY cycles after each grant.
- Includes a load port for program preload by boot logic or the testbench.

---
 rtl/instr_mem_responder.sv | 67 ++++++
 tb/tb_instr_mem_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: instruction-fetch responder; word memory with a fixed-latency,
// in-order read pipeline, outstanding-request limit and a preload write port.
module instr_mem_responder #(
  parameter int MEM_WORDS       = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_req_i,
  input  logic [31:0]      instr_addr_i,
  output logic             instr_gnt_o,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,
  output logic             instr_rvalid_o,
  input  logic             mem_busy_i,
  input  logic             load_we_i,
  input  logic [31:0]      load_addr_i,
  input  logic [31:0]      load_wdata_i,
  output logic [CNT_W-1:0] outstanding_o
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);
  logic [31:0]      r_mem [MEM_WORDS];
  logic             r_vld [LATENCY];
  logic             r_err [LATENCY];
  logic [31:0]      r_dat [LATENCY];
  logic [CNT_W-1:0] r_cnt;
  logic             w_err;
  logic             w_lerr;
  logic [AW-1:0]    w_idx;
  logic [AW-1:0]    w_lidx;
  assign w_idx          = instr_addr_i[AW+1:2];
  assign w_lidx         = load_addr_i[AW+1:2];
  assign w_err          = {1'b0, instr_addr_i} >= BYTES;
  assign w_lerr         = {1'b0, load_addr_i} >= BYTES;
  assign instr_rvalid_o = r_vld[LATENCY-1];
  assign instr_rdata_o  = instr_rvalid_o ? r_dat[LATENCY-1] : '0;
  assign instr_err_o    = instr_rvalid_o & r_err[LATENCY-1];
  assign outstanding_o  = r_cnt;
  // a response retiring this cycle frees its slot for a same-cycle grant
  assign instr_gnt_o    = instr_req_i & ~mem_busy_i & ~rst & ((r_cnt < MAX_C) | instr_rvalid_o);
  always_ff @(posedge clk)
    if (load_we_i && !w_lerr) r_mem[w_lidx] <= load_wdata_i;
  // stage 0 samples the array with a non-blocking read, so a same-edge load returns the old word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i] <= 1'b0;
        r_err[i] <= 1'b0;
        r_dat[i] <= '0;
      end
      r_cnt <= '0;
    end else begin
      r_vld[0] <= instr_gnt_o;
      r_err[0] <= w_err;
      r_dat[0] <= w_err ? '0 : r_mem[w_idx];
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        r_dat[i] <= r_dat[i-1];
      end
      r_cnt <= r_cnt + CNT_W'(instr_gnt_o) - CNT_W'(instr_rvalid_o);
    end
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: two responders (latency 1 and 3) on shared stimulus, checked
// against a due-cycle scoreboard model plus directed vector tables.
module tb_instr_mem_responder;
  localparam int MW = 1024;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic busy = 1'b0;
  logic we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] laddr = '0;
  logic [31:0] wdata = '0;
  logic [1:0] g, rv, er;
  logic [1:0][31:0] rd;
  logic [1:0][1:0] oc;
  int lat [2] = '{1, 3};
  int mo [2] = '{2, 2};
  bit pv [2][4096];
  bit pe [2][4096];
  logic [31:0] pd [2][4096];
  int cnt [2];
  int cyc;
  logic [31:0] mem [MW];
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic req; logic [31:0] addr; logic we; logic [31:0] laddr; logic [31:0] wdata;
    logic eg; logic erv; logic eer; logic [31:0] erd; logic [1:0] eout;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  instr_mem_responder #(.MEM_WORDS(MW), .LATENCY(1), .MAX_OUTSTANDING(2)) u0 (
    .clk(clk), .rst(rst), .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(g[0]),
    .instr_rdata_o(rd[0]), .instr_err_o(er[0]), .instr_rvalid_o(rv[0]), .mem_busy_i(busy),
    .load_we_i(we), .load_addr_i(laddr), .load_wdata_i(wdata), .outstanding_o(oc[0]));
  instr_mem_responder #(.MEM_WORDS(MW), .LATENCY(3), .MAX_OUTSTANDING(2)) u1 (
    .clk(clk), .rst(rst), .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(g[1]),
    .instr_rdata_o(rd[1]), .instr_err_o(er[1]), .instr_rvalid_o(rv[1]), .mem_busy_i(busy),
    .load_we_i(we), .load_addr_i(laddr), .load_wdata_i(wdata), .outstanding_o(oc[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic b, input logic w,
                       input logic [31:0] la, input logic [31:0] wd);
    req = r; addr = a; busy = b; we = w; laddr = la; wdata = wd;
  endtask

  // Responses are scheduled by due cycle; outstanding is the number still scheduled.
  task automatic model_step();
    int s, t;
    logic ev, ee, eg;
    logic [31:0] ed;
    for (int i = 0; i < 2; i++) begin
      s = cyc & 4095;
      ev = pv[i][s];
      ed = ev ? pd[i][s] : 32'h0;
      ee = ev & pe[i][s];
      eg = req & ~busy & ((cnt[i] < mo[i]) || ev);
      chk($sformatf("u%0d_gnt", i), 32'(g[i]), 32'(eg));
      chk($sformatf("u%0d_rvalid", i), 32'(rv[i]), 32'(ev));
      chk($sformatf("u%0d_rdata", i), rd[i], ed);
      chk($sformatf("u%0d_err", i), 32'(er[i]), 32'(ee));
      chk($sformatf("u%0d_outstanding", i), 32'(oc[i]), 32'(cnt[i]));
      if (ev) begin
        pv[i][s] = 1'b0;
        cnt[i]--;
      end
      if (eg) begin
        t = (cyc + lat[i]) & 4095;
        pv[i][t] = 1'b1;
        pe[i][t] = addr >= 32'(MW * 4);
        pd[i][t] = pe[i][t] ? 32'h0 : mem[addr[11:2]];
        cnt[i]++;
      end
    end
    if (we && laddr < 32'(MW * 4)) mem[laddr[11:2]] = wdata;
    cyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0;
      for (int k = 0; k < 4096; k++) pv[i][k] = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_chk(input string nm, input logic eg, input logic erv, input logic eer,
                         input logic [31:0] erd, input logic [1:0] eo);
    @(negedge clk);
    chk({nm, "_gnt"}, 32'(g[0]), 32'(eg));
    chk({nm, "_rvalid"}, 32'(rv[0]), 32'(erv));
    chk({nm, "_err"}, 32'(er[0]), 32'(eer));
    chk({nm, "_rdata"}, rd[0], erd);
    chk({nm, "_out"}, 32'(oc[0]), 32'(eo));
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_gnt%0d", i), 32'(g[i]), 32'h0);
      chk($sformatf("rst_rvalid%0d", i), 32'(rv[i]), 32'h0);
      chk($sformatf("rst_rdata%0d", i), rd[i], 32'h0);
      chk($sformatf("rst_out%0d", i), 32'(oc[i]), 32'h0);
    end
    model_reset();
    cyc = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 64; k++) begin
      w = (k == 0) ? 32'h00000013 : (k == 1) ? 32'h00100093 : (k == 2) ? 32'h00200113 :
          (k == 3) ? 32'h00300193 : (k == 5) ? 32'h55555555 : $urandom;
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'(k * 4), w);
      cycle();
    end
    tbl[0]  = '{1'b1, 32'h0,    1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        2'd0};
    tbl[1]  = '{1'b1, 32'h4,    1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 1'b0, 32'h00000013, 2'd1};
    tbl[2]  = '{1'b1, 32'h8,    1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 1'b0, 32'h00100093, 2'd1};
    tbl[3]  = '{1'b1, 32'hC,    1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 1'b0, 32'h00200113, 2'd1};
    tbl[4]  = '{1'b0, 32'h0,    1'b0, 32'h0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h00300193, 2'd1};
    tbl[5]  = '{1'b0, 32'h0,    1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        2'd0};
    tbl[6]  = '{1'b0, 32'h0,    1'b1, 32'h0,  32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0};
    tbl[7]  = '{1'b1, 32'h2,    1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        2'd0};
    tbl[8]  = '{1'b1, 32'h1000, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 1'b0, 32'h12345678, 2'd1};
    tbl[9]  = '{1'b0, 32'h0,    1'b0, 32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        2'd1};
    tbl[10] = '{1'b0, 32'h0,    1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        2'd0};
    tbl[11] = '{1'b1, 32'h14,   1'b1, 32'h14, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0};
    tbl[12] = '{1'b1, 32'h14,   1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 1'b0, 32'h55555555, 2'd1};
    tbl[13] = '{1'b0, 32'h0,    1'b0, 32'h0,  32'h0,        1'b0, 1'b1, 1'b0, 32'hAAAAAAAA, 2'd1};
    tbl[14] = '{1'b0, 32'h0,    1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        2'd0};
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].req, tbl[i].addr, 1'b0, tbl[i].we, tbl[i].laddr, tbl[i].wdata);
      cyc_chk($sformatf("vec%0d", i), tbl[i].eg, tbl[i].erv, tbl[i].eer, tbl[i].erd, tbl[i].eout);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) cycle();
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc_chk("busy_pre", 1'b1, 1'b0, 1'b0, 32'h0, 2'd0);
    busy = 1'b1;
    cyc_chk("busy1", 1'b0, 1'b1, 1'b0, 32'h00200113, 2'd1);
    cyc_chk("busy2", 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    cyc_chk("busy3", 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    busy = 1'b0;
    cyc_chk("busy_end", 1'b1, 1'b0, 1'b0, 32'h0, 2'd0);
    req = 1'b0;
    cyc_chk("busy_resp", 1'b0, 1'b1, 1'b0, 32'h00200113, 2'd1);
    repeat (4) cycle();
    drive(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) cycle();
    req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out1", 32'(oc[1]), 32'h0);
    chk("arst_rvalid1", 32'(rv[1]), 32'h0);
    chk("arst_rdata1", rd[1], 32'h0);
    chk("arst_out0", 32'(oc[0]), 32'h0);
    rst = 1'b0;
    model_reset();
    repeat (5) cycle();
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc_chk("ret_req", 1'b1, 1'b0, 1'b0, 32'h0, 2'd0);
    req = 1'b0;
    cyc_chk("ret_data", 1'b0, 1'b1, 1'b0, 32'h12345678, 2'd1);
    for (int n = 0; n < 2000; n++) begin
      req = $urandom_range(0, 3) != 0;
      busy = $urandom_range(0, 4) == 0;
      addr = ($urandom_range(0, 9) == 0) ? (32'h1000 | $urandom) : 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
      we = $urandom_range(0, 3) == 0;
      laddr = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 63)) * 4 : 32'($urandom_range(0, 63)) * 4;
      wdata = $urandom;
      cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (5) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
